// File: rtl/melody_sequencer.sv
// Melody sequencer: on a debounced key press, steps through a ROM of
// {midi, duration} entries and drives the tone generator's note input.
module melody_sequencer #(
  parameter int unsigned TICK_DIV        = 187500,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned ROM_DEPTH       = 32,
  parameter logic [ROM_DEPTH*16-1:0] ROM_INIT =
    (ROM_DEPTH*16)'({16'h0000, 16'h4810, 16'h4308, 16'h4008, 16'h3C08}),
  localparam int unsigned IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1
) (
  input  logic             clk12MHz,
  input  logic             rst_n,
  input  logic             key,
  input  logic             loop_en,
  output logic [7:0]       midi,
  output logic             playing,
  output logic [IDX_W-1:0] note_idx
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_PLAY} state_t;

  state_t            state_q, state_d;
  logic              key_s1_q, key_s2_q;
  logic              key_db_q, key_db_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]        midi_q, midi_d;
  logic [7:0]        remaining_q, remaining_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic [15:0]       rom_q;
  logic [15:0]       rom_mem [ROM_DEPTH];

  logic db_settled, press, tick, rom_end, last_entry, note_done;

  // Key path: 2-FF synchroniser idles at the released level.
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= key;
      key_s2_q <= key_s1_q;
    end
  end

  assign db_settled = (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1));
  assign press      = key_db_q & ~key_s2_q & db_settled;

  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = db_cnt_q;
    if (key_s2_q == key_db_q) begin
      db_cnt_d = '0;
    end else if (db_settled) begin
      key_db_d = key_s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Tempo counter only runs in PLAY, so each note starts on a fresh tick.
  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = (state_q == S_PLAY && !tick) ? tick_cnt_q + TICK_W'(1) : '0;

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign rom_mem[gi] = ROM_INIT[gi*16 +: 16];
  end

  always_ff @(posedge clk12MHz) begin
    rom_q <= rom_mem[note_idx_q];
  end

  assign rom_end    = (rom_q[7:0] == 8'd0);
  assign last_entry = (note_idx_q == IDX_W'(ROM_DEPTH - 1));
  assign note_done  = tick && (remaining_q == 8'd1);

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (press) state_d = S_LOAD;
      S_LOAD: state_d = press ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (press)        state_d = S_IDLE;
        else if (rom_end) state_d = loop_en ? S_LOAD : S_IDLE;
        else              state_d = S_PLAY;
      end
      S_PLAY: begin
        if (press)          state_d = S_IDLE;
        else if (note_done) state_d = (last_entry && !loop_en) ? S_IDLE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A press outside IDLE aborts; it outranks a coincident tick.
  always_comb begin
    midi_d      = midi_q;
    note_idx_d  = note_idx_q;
    remaining_d = remaining_q;
    if (press && state_q != S_IDLE) begin
      midi_d     = '0;
      note_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (press) note_idx_d = '0;
        S_WAIT: begin
          if (rom_end) begin
            note_idx_d = '0;
            if (!loop_en) midi_d = '0;
          end else begin
            midi_d      = rom_q[15:8];
            remaining_d = rom_q[7:0];
          end
        end
        S_PLAY: begin
          if (tick) begin
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd2) midi_d = '0;
            if (note_done) begin
              note_idx_d = last_entry ? '0 : note_idx_q + IDX_W'(1);
              if (last_entry && !loop_en) midi_d = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      key_db_q    <= 1'b1;
      db_cnt_q    <= '0;
      tick_cnt_q  <= '0;
      midi_q      <= '0;
      remaining_q <= '0;
      note_idx_q  <= '0;
    end else begin
      key_db_q    <= key_db_d;
      db_cnt_q    <= db_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      midi_q      <= midi_d;
      remaining_q <= remaining_d;
      note_idx_q  <= note_idx_d;
    end
  end

  always_comb begin
    playing = (state_q != S_IDLE);
  end

  assign midi     = midi_q;
  assign note_idx = note_idx_q;

endmodule
